dma_engineer_arbiter: RTL and testbench
=======================================

// Module: dma_engineer_arbiter
// PURPOSE
//  Shares one DMA engineer read port between NUM_CLIENTS layer controllers (conv1, conv2, fc, ...).
//  Each client sees the same req/ack/start_addr/length/dout/dout_en/dout_eop protocol it would see
//  from a private engine. Arbitration is round-robin; a grant is held from request to end of burst.
//  Sits between the layer controllers' weight double-buffer loaders and the single DMA engineer.
// PARAMETERS
//  NUM_CLIENTS  4    number of requesting layer controllers (2..8)
//  ADDR_W       27   width of start_addr and length
//  DATA_W       512  DMA data beat width
//  ID_W         2    clog2(NUM_CLIENTS); width of grant_id
// PORTS
//  clk              in   1                      clock, all logic rising-edge
//  rst              in   1                      asynchronous, active-low reset
//  cl_req           in   NUM_CLIENTS            per-client request, level, held until its ack
//  cl_ack           out  NUM_CLIENTS            per-client ack, 1-cycle pulse
//  cl_start_addr    in   NUM_CLIENTS*ADDR_W     packed; client i at [i*ADDR_W +: ADDR_W]
//  cl_length        in   NUM_CLIENTS*ADDR_W     packed, same layout
//  cl_dout          out  DATA_W                 broadcast copy of dma_dout
//  cl_dout_en       out  NUM_CLIENTS            beat valid, only to the granted client
//  cl_dout_eop      out  NUM_CLIENTS            last beat, only to the granted client
//  dma_req          out  1                      request to the engine
//  dma_ack          in   1                      engine accept, 1-cycle pulse
//  dma_start_addr   out  ADDR_W                 latched address of the granted client
//  dma_length       out  ADDR_W                 latched length of the granted client
//  dma_dout         in   DATA_W                 engine data
//  dma_dout_en      in   1                      engine beat valid
//  dma_dout_eop     in   1                      engine last beat, valid only with dma_dout_en
//  busy             out  1                      high in any state except IDLE
//  grant_id         out  ID_W                   index of the current or last granted client
//  stray_beat       out  1                      sticky error: beat seen while no burst is open
// BEHAVIOUR
//  Reset (rst=0): state IDLE, rr pointer 0, grant_id 0. Register outputs cleared: dma_req,
//    dma_start_addr, dma_length, busy, stray_beat. cl_ack, cl_dout_en and cl_dout_eop are
//    combinational gates and read 0 in IDLE.
//  FSM IDLE -> REQ -> XFER -> IDLE.
//  IDLE: if any cl_req, pick the first set bit at or after the rr pointer, wrapping.
//    Next edge: latch grant_id and the client's addr/length, set dma_req=1, go to REQ.
//  REQ: dma_req stays high until dma_ack.
//    cl_ack[grant_id] = dma_ack, combinational, same cycle.
//    On dma_ack: dma_req=0, go to XFER, rr pointer = grant_id+1 mod NUM_CLIENTS.
//  XFER: cl_dout_en[g] = dma_dout_en; cl_dout_eop[g] = dma_dout_en & dma_dout_eop.
//    Other clients' bits are 0. Forwarding is combinational, zero latency.
//    On the beat with dma_dout_en & dma_dout_eop, go to IDLE.
//    Zero-beat bursts are not supported; the engine always ends with an eop beat.
//  Grant-to-dma_req latency is 1 cycle. A new dma_req is issued no earlier than the cycle after eop.
//  cl_req changes after grant are ignored until the next IDLE.
//    A client dropping req in REQ does not abort the grant.
//  Simultaneous requests: round-robin gives every requester a grant within NUM_CLIENTS bursts.
//  dma_dout_en in IDLE or REQ: beat is not forwarded; stray_beat set, cleared only by reset.
//  dma_dout_eop without dma_dout_en: ignored.
//  dma_ack outside REQ: ignored.
//  Reset mid-burst: immediate return to IDLE. Any later engine beats count as stray.
// STRUCTURE
//  Package dma_arb_pkg: state enum (IDLE, REQ, XFER) and clog2 helper for ID_W.
//  One sub-module, rr_arbiter: NUM_CLIENTS request vector plus pointer in,
//    one-hot grant and index out, combinational.
//  Top level holds the FSM, latches and output gating.
// TESTING
//  1 Single client 1: req, addr 0x100, len 4; ack after 3 cycles; 4 beats with eop on 4th.
//    -> dma_start_addr=0x100, dma_length=4, cl_ack[1] pulses once, cl_dout_en[1] high 4 cycles,
//       no other client bits.
//  2 Clients 0,2,3 request together, rr=0.
//    -> grants in order 0,2,3; each dma_req rises 1 cycle after the previous eop.
//  3 Client 0 re-requests continuously while client 1 waits.
//    -> grants alternate 0,1,0,1.
//  4 dma_dout_en pulses in IDLE.
//    -> no cl_dout_en, stray_beat=1 and stays 1 through later bursts.
//  5 Assert rst in XFER after 2 of 4 beats.
//    -> all outputs 0 immediately, state IDLE; remaining beats set stray_beat after reset release.
//  6 Client drops req during REQ.
//    -> dma_req stays high until dma_ack; the burst still completes to that client.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA engineer arbiter: FSM state encoding,
// default geometry and a constant-evaluable clog2 used to size grant_id.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam int NUM_CLIENTS_DEF = 4;
  localparam int ADDR_W_DEF      = 27;
  localparam int DATA_W_DEF      = 512;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_engineer_arbiter_if.sv
// Client-side and engine-side buses of the arbiter; the arbiter is the slave
// of the layer controllers and the master towards the single DMA engineer.
interface arb_cl_if
  import dma_arb_pkg::*;
#(
  parameter int N  = NUM_CLIENTS_DEF,
  parameter int AW = ADDR_W_DEF,
  parameter int DW = DATA_W_DEF
);
  logic [N-1:0]    cl_req;
  logic [N-1:0]    cl_ack;
  logic [N*AW-1:0] cl_start_addr;
  logic [N*AW-1:0] cl_length;
  logic [DW-1:0]   cl_dout;
  logic [N-1:0]    cl_dout_en;
  logic [N-1:0]    cl_dout_eop;

  modport slave (
    input  cl_req, cl_start_addr, cl_length,
    output cl_ack, cl_dout, cl_dout_en, cl_dout_eop
  );

  modport master (
    output cl_req, cl_start_addr, cl_length,
    input  cl_ack, cl_dout, cl_dout_en, cl_dout_eop
  );
endinterface

interface arb_dma_if
  import dma_arb_pkg::*;
#(
  parameter int AW = ADDR_W_DEF,
  parameter int DW = DATA_W_DEF
);
  logic          dma_req;
  logic          dma_ack;
  logic [AW-1:0] dma_start_addr;
  logic [AW-1:0] dma_length;
  logic [DW-1:0] dma_dout;
  logic          dma_dout_en;
  logic          dma_dout_eop;

  modport master (
    output dma_req, dma_start_addr, dma_length,
    input  dma_ack, dma_dout, dma_dout_en, dma_dout_eop
  );

  modport slave (
    input  dma_req, dma_start_addr, dma_length,
    output dma_ack, dma_dout, dma_dout_en, dma_dout_eop
  );
endinterface

// File: rtl/dma_engineer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; returns one-hot grant, its index and a valid flag.
module rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int N    = NUM_CLIENTS_DEF,
  parameter int ID_W = clog2(NUM_CLIENTS_DEF)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            vld_o
);

  int              k;
  logic [ID_W-1:0] k_idx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      k_idx = ID_W'(k);
      if (!vld_o && req_i[k_idx]) begin
        vld_o        = 1'b1;
        gnt_o[k_idx] = 1'b1;
        idx_o        = k_idx;
      end
    end
  end

endmodule

// File: rtl/dma_engineer_arbiter.sv
// Shares one DMA engineer read port between NUM_CLIENTS layer controllers, round-robin,
// grant held request-to-eop; dma_req one cycle after grant, data forwarded with zero latency.
module dma_engineer_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ID_W        = clog2(NUM_CLIENTS)
) (
  input  logic            clk,
  input  logic            rst,
  arb_cl_if.slave         cl,
  arb_dma_if.master       dma,
  output logic            busy,
  output logic [ID_W-1:0] grant_id,
  output logic            stray_beat
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      len_q, len_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   stray_q, stray_d;

  logic [NUM_CLIENTS-1:0] pick_oh;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_vld;
  logic [ADDR_W-1:0]      pick_addr;
  logic [ADDR_W-1:0]      pick_len;
  logic [NUM_CLIENTS-1:0] gid_oh;
  logic [NUM_CLIENTS-1:0] ack_c, en_c, eop_c;
  logic [DATA_W-1:0]      dout_bcast;

  rr_arbiter #(
    .N    (NUM_CLIENTS),
    .ID_W (ID_W)
  ) u_rr (
    .req_i (cl.cl_req),
    .ptr_i (rr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // AND-OR select of the winner's descriptor straight off the one-hot grant.
  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_oh[i]) begin
        pick_addr = pick_addr | cl.cl_start_addr[i*ADDR_W +: ADDR_W];
        pick_len  = pick_len  | cl.cl_length[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    gid_oh        = '0;
    gid_oh[gid_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    len_d   = len_q;
    req_d   = req_q;
    ack_c   = '0;
    en_c    = '0;
    eop_c   = '0;
    stray_d = stray_q | (dma.dma_dout_en && (state_q != XFER));

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_idx;
          addr_d  = pick_addr;
          len_d   = pick_len;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dma.dma_ack) begin
          ack_c   = gid_oh;
          req_d   = 1'b0;
          rr_d    = (gid_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : gid_q + ID_W'(1);
          state_d = XFER;
        end
      end
      XFER: begin
        if (dma.dma_dout_en) begin
          en_c = gid_oh;
          if (dma.dma_dout_eop) begin
            eop_c   = gid_oh;
            state_d = IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign dout_bcast         = dma.dma_dout;
  assign cl.cl_dout         = dout_bcast;
  assign cl.cl_ack          = ack_c;
  assign cl.cl_dout_en      = en_c;
  assign cl.cl_dout_eop     = eop_c;
  assign dma.dma_req        = req_q;
  assign dma.dma_start_addr = addr_q;
  assign dma.dma_length     = len_q;
  assign busy               = busy_q;
  assign grant_id           = gid_q;
  assign stray_beat         = stray_q;

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// Scoreboarded bench: predicted grants are queued when requests are driven and
// checked when the arbiter raises dma_req; a behavioural engine serves each burst.
module tb_dma_engineer_arbiter;
  import dma_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 27;
  localparam int DW = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;
  logic       stray_beat;

  always #5 clk = ~clk;

  arb_cl_if  #(.N(N), .AW(AW), .DW(DW)) cli ();
  arb_dma_if #(.AW(AW), .DW(DW))        dmi ();

  dma_engineer_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .ID_W        (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cl         (cli.slave),
    .dma        (dmi.master),
    .busy       (busy),
    .grant_id   (grant_id),
    .stray_beat (stray_beat)
  );

  typedef struct {
    int          id;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rr_m  = 0;
  logic [AW-1:0] addr_m [N];
  logic [AW-1:0] len_m  [N];

  task automatic set_client(input int c, input logic [AW-1:0] a, input logic [AW-1:0] l);
    addr_m[c] = a;
    len_m[c]  = l;
    cli.cl_start_addr[c*AW +: AW] = a;
    cli.cl_length[c*AW +: AW]     = l;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Predict grant order for a pending set; clients in keep re-request after their ack.
  task automatic push_order(input logic [N-1:0] pending, input logic [N-1:0] keep, input int count);
    logic [N-1:0] m;
    int g;
    m = pending;
    for (int i = 0; i < count; i++) begin
      g = pick(m, rr_m);
      if (g < 0) break;
      sb.push_back('{id: g, addr: addr_m[g], len: len_m[g]});
      if (!keep[g]) m[g] = 1'b0;
      rr_m = (g + 1) % N;
    end
  endtask

  // Engine model for one burst; rst_at >= 0 asserts reset on that beat index.
  task automatic serve(input int ack_dly, input int nbeats, input bit drop,
                       input logic [N-1:0] keep, input int rst_at, output int waited);
    exp_t          e;
    logic [N-1:0]  oh;
    logic [N-1:0]  eop_exp;
    logic [DW-1:0] d;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (dmi.dma_req === 1'b1) break;
    end
    n_cmp++;
    if (dmi.dma_req !== 1'b1) begin
      $display("FAIL req_timeout: dma_req=%b required 1", dmi.dma_req);
      n_bad++;
      return;
    end
    n_cmp++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_grant: grant_id=%0d with empty scoreboard", grant_id);
      n_bad++;
      return;
    end
    e  = sb.pop_front();
    oh = '0;
    oh[e.id] = 1'b1;
    n_cmp++;
    if (grant_id !== 2'(e.id)) begin
      $display("FAIL grant_id: got %0d required %0d", grant_id, e.id); n_bad++;
    end
    n_cmp++;
    if (dmi.dma_start_addr !== e.addr) begin
      $display("FAIL start_addr: got %h required %h", dmi.dma_start_addr, e.addr); n_bad++;
    end
    n_cmp++;
    if (dmi.dma_length !== e.len) begin
      $display("FAIL length: got %h required %h", dmi.dma_length, e.len); n_bad++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_req: got %b required 1", busy); n_bad++;
    end
    if (drop) begin
      @(posedge clk); #1;
      cli.cl_req[e.id] = 1'b0;
    end
    repeat (ack_dly) begin
      @(negedge clk);
      n_cmp++;
      if (dmi.dma_req !== 1'b1 || cli.cl_ack !== '0) begin
        $display("FAIL req_hold: dma_req=%b cl_ack=%b required 1/0000", dmi.dma_req, cli.cl_ack);
        n_bad++;
      end
    end
    @(posedge clk); #1;
    dmi.dma_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cli.cl_ack !== oh) begin
      $display("FAIL cl_ack: got %b required %b", cli.cl_ack, oh); n_bad++;
    end
    @(posedge clk); #1;
    dmi.dma_ack = 1'b0;
    if (!keep[e.id]) cli.cl_req[e.id] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dmi.dma_req !== 1'b0 || cli.cl_ack !== '0 || busy !== 1'b1) begin
      $display("FAIL post_ack: dma_req=%b cl_ack=%b busy=%b required 0/0000/1",
               dmi.dma_req, cli.cl_ack, busy);
      n_bad++;
    end
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      d = {16{$urandom()}};
      dmi.dma_dout     = d;
      dmi.dma_dout_en  = 1'b1;
      dmi.dma_dout_eop = (b == nbeats - 1);
      if (b == rst_at) begin
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || dmi.dma_req !== 1'b0 || cli.cl_dout_en !== '0 ||
            grant_id !== 2'd0 || stray_beat !== 1'b0 || dmi.dma_start_addr !== '0) begin
          $display("FAIL reset_mid: busy=%b req=%b en=%b gid=%0d stray=%b addr=%h required all 0",
                   busy, dmi.dma_req, cli.cl_dout_en, grant_id, stray_beat, dmi.dma_start_addr);
          n_bad++;
        end
        @(posedge clk); #1;
        rst  = 1'b1;
        rr_m = 0;
        @(posedge clk); #1;
        dmi.dma_dout_eop = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cli.cl_dout_en !== '0 || stray_beat !== 1'b1) begin
          $display("FAIL stray_after_reset: en=%b stray=%b required 0000/1", cli.cl_dout_en, stray_beat);
          n_bad++;
        end
        @(posedge clk); #1;
        dmi.dma_dout_en  = 1'b0;
        dmi.dma_dout_eop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || stray_beat !== 1'b1) begin
          $display("FAIL idle_after_reset: busy=%b stray=%b required 0/1", busy, stray_beat);
          n_bad++;
        end
        return;
      end
      @(negedge clk);
      eop_exp = (b == nbeats - 1) ? oh : '0;
      n_cmp++;
      if (cli.cl_dout_en !== oh || cli.cl_dout_eop !== eop_exp || cli.cl_dout !== d) begin
        $display("FAIL beat%0d: en=%b eop=%b required %b/%b dout_match=%b",
                 b, cli.cl_dout_en, cli.cl_dout_eop, oh, eop_exp, cli.cl_dout === d);
        n_bad++;
      end
    end
    @(posedge clk); #1;
    dmi.dma_dout_en  = 1'b0;
    dmi.dma_dout_eop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dmi.dma_req !== 1'b0 || cli.cl_dout_en !== '0) begin
      $display("FAIL after_eop: busy=%b req=%b en=%b required 0/0/0000",
               busy, dmi.dma_req, cli.cl_dout_en);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    cli.cl_req       = '0;
    dmi.dma_ack      = 1'b0;
    dmi.dma_dout     = '0;
    dmi.dma_dout_en  = 1'b0;
    dmi.dma_dout_eop = 1'b0;
    rr_m             = 0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || dmi.dma_req !== 1'b0 || grant_id !== 2'd0 || stray_beat !== 1'b0 ||
        dmi.dma_start_addr !== '0 || dmi.dma_length !== '0 || cli.cl_ack !== '0 ||
        cli.cl_dout_en !== '0 || cli.cl_dout_eop !== '0) begin
      $display("FAIL reset_state: busy=%b req=%b gid=%0d stray=%b addr=%h len=%h ack=%b en=%b required all 0",
               busy, dmi.dma_req, grant_id, stray_beat, dmi.dma_start_addr, dmi.dma_length,
               cli.cl_ack, cli.cl_dout_en);
      n_bad++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int w;
    @(posedge clk); #1;
    cli.cl_req[1] = 1'b1;
    push_order(4'b0010, 4'b0000, 1);
    serve(3, 4, 1'b0, 4'b0000, -1, w);
  endtask

  task automatic test_simultaneous();
    int w;
    @(posedge clk); #1;
    cli.cl_req = 4'b1101;
    push_order(4'b1101, 4'b0000, 3);
    serve(1, 2, 1'b0, 4'b0000, -1, w);
    for (int i = 0; i < 2; i++) begin
      serve(0, 3, 1'b0, 4'b0000, -1, w);
      n_cmp++;
      if (w !== 1) begin
        $display("FAIL regrant_latency: dma_req after %0d cycles required 1", w); n_bad++;
      end
    end
  endtask

  task automatic test_fairness();
    int w;
    @(posedge clk); #1;
    cli.cl_req = 4'b0011;
    push_order(4'b0011, 4'b0001, 2);
    serve(1, 2, 1'b0, 4'b0001, -1, w);
    serve(0, 1, 1'b0, 4'b0001, -1, w);
    @(posedge clk); #1;
    cli.cl_req[1] = 1'b1;
    push_order(4'b0011, 4'b0001, 2);
    serve(2, 2, 1'b0, 4'b0001, -1, w);
    @(posedge clk); #1;
    cli.cl_req[0] = 1'b0;
    serve(0, 2, 1'b0, 4'b0000, -1, w);
  endtask

  task automatic test_stray();
    int w;
    n_cmp++;
    if (stray_beat !== 1'b0) begin
      $display("FAIL stray_initial: got %b required 0", stray_beat); n_bad++;
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      dmi.dma_dout_en  = 1'b1;
      dmi.dma_dout_eop = (i == 1);
      @(negedge clk);
      n_cmp++;
      if (cli.cl_dout_en !== '0 || cli.cl_dout_eop !== '0) begin
        $display("FAIL stray_forward: en=%b eop=%b required 0000/0000", cli.cl_dout_en, cli.cl_dout_eop);
        n_bad++;
      end
    end
    @(posedge clk); #1;
    dmi.dma_dout_en  = 1'b0;
    dmi.dma_dout_eop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stray_beat !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL stray_set: stray=%b busy=%b required 1/0", stray_beat, busy); n_bad++;
    end
    @(posedge clk); #1;
    cli.cl_req[2] = 1'b1;
    push_order(4'b0100, 4'b0000, 1);
    serve(1, 3, 1'b0, 4'b0000, -1, w);
    n_cmp++;
    if (stray_beat !== 1'b1) begin
      $display("FAIL stray_sticky: got %b required 1", stray_beat); n_bad++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    @(posedge clk); #1;
    cli.cl_req[2] = 1'b1;
    push_order(4'b0100, 4'b0000, 1);
    serve(1, 4, 1'b0, 4'b0000, 2, w);
  endtask

  task automatic test_drop_req();
    int w;
    @(posedge clk); #1;
    cli.cl_req[3] = 1'b1;
    push_order(4'b1000, 4'b0000, 1);
    serve(4, 2, 1'b1, 4'b0000, -1, w);
    n_cmp++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_left: %0d entries required 0", sb.size()); n_bad++;
    end
  endtask

  initial begin
    cli.cl_req        = '0;
    cli.cl_start_addr = '0;
    cli.cl_length     = '0;
    set_client(0, 27'h0000040, 27'd2);
    set_client(1, 27'h0000100, 27'd4);
    set_client(2, 27'h0000300, 27'd4);
    set_client(3, 27'h7ABCDE0, 27'h7FFFFFF);
    test_reset();
    test_single();
    test_reset();
    test_simultaneous();
    test_fairness();
    test_stray();
    test_reset_mid_burst();
    test_drop_req();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
